// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_barrel_shifter
//  Description : Fully pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA and
//                optional ROL). One log2 shift stage per pipeline register,
//                valid/ready backpressure, synchronous flush, sideband tag.
//                Optional feature macro: BARREL_ROTATE_EN (enables ROL on
//                op 2'b11; otherwise op 2'b11 passes data through unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;

    // Stage registers. The shift amount is carried pre-aligned so that the
    // bit governing the next stage is always the MSB.
    logic [SHAMT_W-1:0] r_valid;
    logic [WIDTH-1:0]   r_data  [SHAMT_W];
    logic [SHAMT_W-1:0] r_shamt [SHAMT_W];
    logic [1:0]         r_op    [SHAMT_W];
    logic               r_sign  [SHAMT_W];
    logic [TAG_W-1:0]   r_tag   [SHAMT_W];

    // Per-stage sources (stage 0 from the ports, stage i from stage i-1).
    logic               w_src_valid [SHAMT_W];
    logic [WIDTH-1:0]   w_src_data  [SHAMT_W];
    logic [SHAMT_W-1:0] w_src_shamt [SHAMT_W];
    logic [1:0]         w_src_op    [SHAMT_W];
    logic               w_src_sign  [SHAMT_W];
    logic [TAG_W-1:0]   w_src_tag   [SHAMT_W];

    // Per-stage next values.
    logic [SHAMT_W-1:0] w_nxt_valid;
    logic [WIDTH-1:0]   w_nxt_data  [SHAMT_W];
    logic [SHAMT_W-1:0] w_nxt_shamt [SHAMT_W];

    logic w_adv;
    logic w_unused;

    // One shift step of a fixed distance; the fill depends on the op.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             sgn,
        input int               amt
    );
        logic [WIDTH-1:0] res;
        res = d;
        case (op)
            c_OP_SLL: res = d << amt;
            c_OP_SRL: res = d >> amt;
            c_OP_SRA: res = sgn ? ~((~d) >> amt) : (d >> amt);
            default: begin
`ifdef BARREL_ROTATE_EN
                res = (d << amt) | (d >> (WIDTH - amt));
`else
                res = d;
`endif
            end
        endcase
        return res;
    endfunction

    // Pipeline advances whenever the output slot is empty or being drained.
    assign w_adv     = out_ready || !out_valid;
    assign in_ready  = w_adv && !flush;

    assign out_valid = r_valid[SHAMT_W-1];
    assign out_data  = r_data[SHAMT_W-1];
    assign out_tag   = r_tag[SHAMT_W-1];
    assign busy      = |r_valid;

    // Final-stage sideband fields have no consumer.
    assign w_unused  = ^{r_shamt[SHAMT_W-1], r_op[SHAMT_W-1], r_sign[SHAMT_W-1]};

    // Stage 0 is fed straight from the input port; the sign is captured here.
    assign w_src_valid[0] = in_valid && in_ready;
    assign w_src_data[0]  = in_data;
    assign w_src_shamt[0] = in_shamt;
    assign w_src_op[0]    = in_op;
    assign w_src_sign[0]  = in_data[WIDTH-1];
    assign w_src_tag[0]   = in_tag;

    generate
        for (genvar gi = 1; gi < SHAMT_W; gi++) begin : g_src
            assign w_src_valid[gi] = r_valid[gi-1];
            assign w_src_data[gi]  = r_data[gi-1];
            assign w_src_shamt[gi] = r_shamt[gi-1];
            assign w_src_op[gi]    = r_op[gi-1];
            assign w_src_sign[gi]  = r_sign[gi-1];
            assign w_src_tag[gi]   = r_tag[gi-1];
        end
    endgenerate

    // Stage i applies a shift of WIDTH>>(i+1) when its shamt bit is set.
    always_comb begin
        for (int i = 0; i < SHAMT_W; i++) begin
            w_nxt_valid[i] = w_src_valid[i];
            w_nxt_shamt[i] = w_src_shamt[i] << 1;
            w_nxt_data[i]  = w_src_data[i];
            if (w_src_shamt[i][SHAMT_W-1]) begin
                w_nxt_data[i] = f_shift(w_src_data[i], w_src_op[i],
                                        w_src_sign[i], WIDTH >> (i + 1));
            end
        end
    end

    // Stage registers: reset clears everything, flush kills valids, and all
    // stages move together only when the output can advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < SHAMT_W; i++) begin
                r_data[i]  <= '0;
                r_shamt[i] <= '0;
                r_op[i]    <= '0;
                r_sign[i]  <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid <= w_nxt_valid;
            for (int i = 0; i < SHAMT_W; i++) begin
                r_data[i]  <= w_nxt_data[i];
                r_shamt[i] <= w_nxt_shamt[i];
                r_op[i]    <= w_src_op[i];
                r_sign[i]  <= w_src_sign[i];
                r_tag[i]   <= w_src_tag[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_barrel_shifter
//  Description : Directed self-checking bench for pipelined_barrel_shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int SHAMT_W = 5;

    logic               clock = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    int n_vec = 0;
    int n_bad = 0;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single op with full latency check: idle for 3 edges after accept,
    // result visible after the 5th edge (accept included), then drained.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] d, input logic [4:0] sh,
                          input logic [4:0] tg, input logic [31:0] exp);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_shamt  = sh;
        in_tag    = tg;
        out_ready = 1'b1;
        #1;
        chk({name, "_rdy"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk({name, "_early"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_vld"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(exp));
        chk({name, "_tag"}, 64'(out_tag), 64'(tg));
        tick();
        chk({name, "_drain_vld"}, 64'(out_valid), 64'd0);
        chk({name, "_drain_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int nxt;
        int exp_tag;
        int got_n;
        int stall;
        bit seen_first;
        bit acc;
        bit cons;
        logic [31:0] rol_exp;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic shifts
        run_op("sll8",  2'b00, 32'h0000_00FF, 5'd8,  5'd1, 32'h0000_FF00);
        run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 5'd2, 32'h0000_0001);
        run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 5'd3, 32'hFFFF_FFFF);
        run_op("sra4",  2'b10, 32'h7FFF_FFF0, 5'd4,  5'd4, 32'h07FF_FFFF);

        // shamt = 0 for every op
        run_op("z_sll", 2'b00, 32'hDEAD_BEEF, 5'd0, 5'd5, 32'hDEAD_BEEF);
        run_op("z_srl", 2'b01, 32'hDEAD_BEEF, 5'd0, 5'd6, 32'hDEAD_BEEF);
        run_op("z_sra", 2'b10, 32'hDEAD_BEEF, 5'd0, 5'd7, 32'hDEAD_BEEF);
        run_op("z_rol", 2'b11, 32'hDEAD_BEEF, 5'd0, 5'd8, 32'hDEAD_BEEF);

        // Rotate (or pass-through when rotate is not built)
`ifdef BARREL_ROTATE_EN
        rol_exp = 32'h0000_0018;
`else
        rol_exp = 32'h8000_0001;
`endif
        run_op("rol4", 2'b11, 32'h8000_0001, 5'd4, 5'd9, rol_exp);

        // Back-to-back stream, tags 1..6, SLL k by k, stall 3 cycles on first result
        nxt        = 1;
        exp_tag    = 1;
        got_n      = 0;
        stall      = 0;
        seen_first = 1'b0;
        for (int c = 0; c < 40 && got_n < 6; c++) begin
            in_valid = (nxt <= 6);
            in_op    = 2'b00;
            in_data  = 32'(nxt);
            in_shamt = 5'(nxt);
            in_tag   = 5'(nxt);
            if (out_valid && !seen_first) begin
                seen_first = 1'b1;
                stall      = 3;
            end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            #1;
            if (!out_ready) chk("b2b_stall_in_ready", 64'(in_ready), 64'd0);
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                chk("b2b_tag", 64'(out_tag), 64'(exp_tag));
                chk("b2b_data", 64'(out_data), 64'(32'(exp_tag) << exp_tag));
                exp_tag++;
                got_n++;
            end
            tick();
            if (acc) nxt++;
        end
        chk("b2b_count", 64'(got_n), 64'd6);
        chk("b2b_accepted", 64'(nxt), 64'd7);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("b2b_no_dup", 64'(out_valid), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd0);

        // Flush with a concurrent input
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_op    = 2'b00;
            in_data  = 32'h1;
            in_shamt = 5'd1;
            in_tag   = 5'(10 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd13;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        cons = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) cons = 1'b1;
        end
        chk("flush_no_emit", 64'(cons), 64'd0);
        run_op("post_flush", 2'b00, 32'h3, 5'd2, 5'd14, 32'hC);

        // Asynchronous reset mid-pipeline with the result held at the output
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_data   = 32'hA5;
        in_shamt  = 5'd4;
        in_tag    = 5'd21;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("arst_pre_vld", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_out_tag", 64'(out_tag), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        cons = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) cons = 1'b1;
        end
        chk("arst_no_emit", 64'(cons), 64'd0);
        run_op("post_rst", 2'b00, 32'h1, 5'd1, 5'd22, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
